// File: rtl/mux_share_arbiter_if.sv
// mux_share_arbiter_if: requester/data inputs and grant/mux outputs of the shared path arbiter
interface mux_share_arbiter_if #(
  parameter int WIDTH = 2
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] z;
  logic             z_valid;
  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, z, z_valid
  );
  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, z, z_valid
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-requester round-robin arbiter sharing one registered 2:1 mux datapath
module mux_share_arbiter #(
  parameter int WIDTH    = 2,
  parameter int HOLD_CYC = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_share_arbiter_if.slave   bus_if
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [7:0] CNT_MAX = 8'(HOLD_CYC - 1);
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_a_q, last_a_d;
  logic             sel_q, sel_d;
  logic             z_valid_q, z_valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             enter;
  // Owner selection with tenure limit; z captures the current owner's data one cycle behind the grant
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (bus_if.req_a && !(bus_if.req_b && last_a_q)) ? OWN_A : bus_if.req_b ? OWN_B : IDLE;
    else if (state_q == OWN_A)
      state_d = !bus_if.req_a ? (bus_if.req_b ? OWN_B : IDLE) :
                (bus_if.req_b && cnt_q == CNT_MAX) ? OWN_B : OWN_A;
    else
      state_d = !bus_if.req_b ? (bus_if.req_a ? OWN_A : IDLE) :
                (bus_if.req_a && cnt_q == CNT_MAX) ? OWN_A : OWN_B;
    enter     = state_d != IDLE && state_d != state_q;
    cnt_d     = enter ? '0 : (state_q != IDLE && cnt_q != CNT_MAX) ? cnt_q + 8'd1 : cnt_q;
    last_a_d  = enter ? state_d == OWN_A : last_a_q;
    sel_d     = enter ? state_d == OWN_A : sel_q;
    z_valid_d = state_q != IDLE;
    z_d       = state_q == IDLE ? z_q : sel_q ? bus_if.a : bus_if.b;
  end
  // State registers; reset favours A by recording B as last served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_a_q  <= 1'b0;
      sel_q     <= 1'b0;
      z_valid_q <= 1'b0;
      z_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_a_q  <= last_a_d;
      sel_q     <= sel_d;
      z_valid_q <= z_valid_d;
      z_q       <= z_d;
    end
  end
  assign bus_if.gnt_a   = state_q == OWN_A;
  assign bus_if.gnt_b   = state_q == OWN_B;
  assign bus_if.sel     = sel_q;
  assign bus_if.z       = z_q;
  assign bus_if.z_valid = z_valid_q;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed vector table, hand sequences and a random run against a reference model
module tb_mux_share_arbiter;
  localparam int WIDTH = 2;
  localparam int HOLD  = 4;
  typedef struct {
    logic       ra, rb;
    logic [1:0] a, b;
    logic       ga, gb, sel;
    logic [1:0] z;
    logic       zv;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[$];
  int   m_owner, m_held;
  logic m_last_a, m_sel, m_zv;
  logic [1:0] m_z;
  mux_share_arbiter_if #(.WIDTH(WIDTH)) bus_if ();
  mux_share_arbiter #(.WIDTH(WIDTH), .HOLD_CYC(HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_if(bus_if.slave)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic ra, logic rb, logic [1:0] a, logic [1:0] b,
                              logic ga, logic gb, logic sel, logic [1:0] z, logic zv);
    vec_t v;
    v.ra = ra; v.rb = rb; v.a = a; v.b = b;
    v.ga = ga; v.gb = gb; v.sel = sel; v.z = z; v.zv = zv;
    return v;
  endfunction
  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, required %0h", name, idx, $time, act, exp);
    end
  endtask
  task automatic chk_all(string tag, int idx, logic ga, logic gb, logic sel, logic [1:0] z, logic zv);
    chk({tag, ".gnt_a"}, idx, 8'(bus_if.gnt_a), 8'(ga));
    chk({tag, ".gnt_b"}, idx, 8'(bus_if.gnt_b), 8'(gb));
    chk({tag, ".sel"}, idx, 8'(bus_if.sel), 8'(sel));
    chk({tag, ".z"}, idx, 8'(bus_if.z), 8'(z));
    chk({tag, ".z_valid"}, idx, 8'(bus_if.z_valid), 8'(zv));
  endtask
  // drive just after a falling edge, let one rising edge pass, return on the next falling edge
  task automatic step(logic ra, logic rb, logic [1:0] a, logic [1:0] b);
    bus_if.req_a = ra;
    bus_if.req_b = rb;
    bus_if.a = a;
    bus_if.b = b;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // reference: owner by plain rules, tenure counted as cycles held, z lags the grant by one cycle
  task automatic model(logic ra, logic rb, logic [1:0] a, logic [1:0] b);
    int nxt;
    logic mine, other;
    m_zv = m_owner != 0;
    if (m_owner != 0) m_z = (m_owner == 1) ? a : b;
    if (m_owner == 0) begin
      if (ra && rb) nxt = m_last_a ? 2 : 1;
      else if (ra) nxt = 1;
      else if (rb) nxt = 2;
      else nxt = 0;
    end else begin
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (!mine) nxt = other ? 3 - m_owner : 0;
      else if (other && m_held >= HOLD) nxt = 3 - m_owner;
      else nxt = m_owner;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_held = 1;
      m_last_a = nxt == 1;
      m_sel = nxt == 1;
    end else m_held++;
    m_owner = nxt;
  endtask
  initial begin
    logic ra, rb;
    logic [1:0] da, db;
    vec_t v;
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 2'b00, 0));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 0, 1, 0, 2'b01, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 0, 1, 0, 2'b11, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 0, 1, 0, 2'b11, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 0, 1, 0, 2'b11, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 2'b11, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(0, 1, 2'b01, 2'b11, 0, 1, 0, 2'b01, 1));
    vecs.push_back(mk(0, 0, 2'b01, 2'b11, 0, 0, 0, 2'b11, 1));
    vecs.push_back(mk(0, 0, 2'b01, 2'b11, 0, 0, 0, 2'b11, 0));
    vecs.push_back(mk(0, 0, 2'b01, 2'b11, 0, 0, 0, 2'b11, 0));
    vecs.push_back(mk(1, 0, 2'b10, 2'b11, 1, 0, 1, 2'b11, 0));
    vecs.push_back(mk(0, 0, 2'b10, 2'b11, 0, 0, 1, 2'b10, 1));
    vecs.push_back(mk(0, 0, 2'b10, 2'b11, 0, 0, 1, 2'b10, 0));
    vecs.push_back(mk(0, 0, 2'b10, 2'b11, 0, 0, 1, 2'b10, 0));
    vecs.push_back(mk(0, 0, 2'b10, 2'b11, 0, 0, 1, 2'b10, 0));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 0, 1, 0, 2'b10, 0));
    vecs.push_back(mk(1, 1, 2'b01, 2'b11, 0, 1, 0, 2'b11, 1));
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 2'b00, 0);
    rst_n = 1'b1;
    // round robin, early release, idle hold and tie-after-idle sequence
    foreach (vecs[i]) begin
      v = vecs[i];
      step(v.ra, v.rb, v.a, v.b);
      chk_all("vec", i, v.ga, v.gb, v.sel, v.z, v.zv);
    end
    // asynchronous reset while B owns the path, checked before any clock edge
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 2'b01, 2'b11);
    chk_all("post_rst", 0, 1, 0, 1, 2'b00, 0);
    // lone requester keeps ownership well past the tenure limit
    reset_pulse();
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 2'b10, 2'b00);
      chk_all("single", i, 1, 0, 1, (i >= 2) ? 2'b10 : 2'b00, i >= 2);
    end
    step(0, 0, 2'b10, 2'b00);
    chk_all("single", 11, 0, 0, 1, 2'b10, 1);
    step(0, 0, 2'b10, 2'b00);
    chk_all("single", 12, 0, 0, 1, 2'b10, 0);
    // random traffic against the reference model
    reset_pulse();
    m_owner = 0; m_held = 0; m_last_a = 1'b0; m_sel = 1'b0; m_z = '0; m_zv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom_range(0, 3) != 0;
      rb = $urandom_range(0, 2) != 0;
      da = 2'($urandom);
      db = 2'($urandom);
      step(ra, rb, da, db);
      model(ra, rb, da, db);
      chk_all("rand", i, m_owner == 1, m_owner == 2, m_sel, m_z, m_zv);
      chk("rand.excl", i, 8'(bus_if.gnt_a & bus_if.gnt_b), 8'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
